// File: rtl/tile_pkg.sv
// Shared types and constants for the tile fetch stage and its map RAM.
package tile_pkg;

  typedef logic [3:0] tile_code_t;

  typedef enum logic {INIT, RUN} fetch_state_t;

  localparam int TILE_W     = 8;
  localparam int TILE_SHIFT = 3;

  localparam tile_code_t BLANK_CODE      = 4'hF;
  localparam tile_code_t DEBUG_GRID_CODE = 4'h9;

  function automatic int map_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 4-bit simple dual-port synchronous RAM, read-first on address collision.
module tile_map_ram
  import tile_pkg::*;
#(
  parameter int DEPTH = 4800,
  parameter int AW    = map_addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  tile_code_t mem [DEPTH];

  // Read samples the array before the same-edge write lands: old data wins.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_fetch.sv
// Pixel -> tile-code fetch stage feeding sprite_map, with init sweep and map write port.
// Optional: define TILE_GRID_DEBUG_EN to overlay the 8x8 tile grid in DEBUG_GRID_CODE.
module tile_fetch
  import tile_pkg::*;
#(
  parameter int         H_RES     = 640,
  parameter int         V_RES     = 480,
  parameter int         MAP_COLS  = 80,
  parameter int         MAP_ROWS  = 60,
  parameter logic [3:0] INIT_CODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       de_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [3:0] wr_code,
  output logic [3:0] sprite_code,
  output logic [2:0] sx,
  output logic [2:0] sy,
  output logic       de_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       init_done
);

  localparam int DEPTH  = MAP_COLS * MAP_ROWS;
  localparam int AW     = map_addr_w(DEPTH);
  localparam int STAGES = 2;

  // Constant multiply by MAP_COLS as a sum of shifted row terms.
  function automatic logic [AW-1:0] row_base(input logic [6:0] r);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++)
      if (MAP_COLS[i]) acc = acc + (AW'(r) << i);
    return acc;
  endfunction

  fetch_state_t  state;
  logic [AW-1:0] sweep;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [3:0]    ram_wdata;
  tile_code_t    rd_code;

  logic [6:0]    pcol, prow;
  logic          in_rng;
  logic [AW-1:0] vaddr;

  logic [AW-1:0]           s1_addr;
  logic [STAGES:1]         ok_pipe;
  logic [STAGES:1][2:0]    vld_pipe;
  logic [2:0]              s1_sx, s1_sy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep     <= '0;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (sweep == AW'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase
    end
  end

  // Single RAM write port: sweep owns it in INIT, game writes in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = sweep;
    ram_wdata = INIT_CODE;
    if (state == INIT) begin
      ram_we = 1'b1;
    end else if (wr_valid && wr_ready &&
                 wr_col < 7'(MAP_COLS) && wr_row < 6'(MAP_ROWS)) begin
      ram_we    = 1'b1;
      ram_waddr = row_base({1'b0, wr_row}) + AW'(wr_col);
      ram_wdata = wr_code;
    end
  end

  assign pcol   = 7'(px >> TILE_SHIFT);
  assign prow   = 7'(py >> TILE_SHIFT);
  assign in_rng = de_in && (px < 10'(H_RES)) && (py < 10'(V_RES));
  assign vaddr  = row_base(prow) + AW'(pcol);

  // Out-of-range pixels read cell 0 so the RAM index stays in bounds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_addr  <= '0;
      s1_sx    <= '0;
      s1_sy    <= '0;
      ok_pipe  <= '0;
      vld_pipe <= '0;
      sx       <= '0;
      sy       <= '0;
    end else begin
      s1_addr     <= in_rng ? vaddr : '0;
      s1_sx       <= px[2:0];
      s1_sy       <= py[2:0];
      ok_pipe[1]  <= in_rng && (state == RUN);
      ok_pipe[2]  <= ok_pipe[1];
      vld_pipe[1] <= {de_in, hs_in, vs_in};
      vld_pipe[2] <= vld_pipe[1];
      sx          <= s1_sx;
      sy          <= s1_sy;
    end
  end

  assign {de_out, hs_out, vs_out} = vld_pipe[STAGES];

  tile_map_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (rd_code)
  );

  always_comb begin
    sprite_code = BLANK_CODE;
    if (ok_pipe[STAGES]) begin
      sprite_code = rd_code;
`ifdef TILE_GRID_DEBUG_EN
      if (sx == 3'd0 || sy == 3'd0) sprite_code = DEBUG_GRID_CODE;
`endif
    end
  end

endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: vector table plus init, write, read-first and reset sequences.
module tb_tile_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] px, py;
  logic       de_in, hs_in, vs_in;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [3:0] wr_code;
  logic [3:0] sprite_code;
  logic [2:0] sx, sy;
  logic       de_out, hs_out, vs_out, init_done;

  int checks = 0;
  int errors = 0;
  logic [3:0] mdl [4800];

  always #5 clk = ~clk;

  tile_fetch dut (
    .clk(clk), .rst_n(rst_n), .px(px), .py(py),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code),
    .sprite_code(sprite_code), .sx(sx), .sy(sy),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .init_done(init_done)
  );

  typedef struct {
    string      name;
    logic [9:0] px, py;
    logic       de, hs, vs;
    logic       ok;
    logic [3:0] ram;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_code(input logic [3:0] ram, input logic ok,
                                          input logic [2:0] x, input logic [2:0] y);
    if (!ok) return 4'hF;
`ifdef TILE_GRID_DEBUG_EN
    if (x == 3'd0 || y == 3'd0) return 4'h9;
`endif
    return ram;
  endfunction

  task automatic fill_model();
    for (int i = 0; i < 4800; i++) mdl[i] = 4'hF;
  endtask

  // Called right after rst_n is released on a negedge; counts cycles until ready.
  task automatic init_wait(input string nm);
    int n = 0;
    int bad = 0;
    px = 10'd0; py = 10'd0; de_in = 1'b1;
    while (!wr_ready && n < 6000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (sprite_code !== 4'hF) bad++;
      if (init_done !== wr_ready) bad++;
    end
    chk({nm, "_cycles"}, n, 4800);
    chk({nm, "_init_done"}, init_done, 1);
    chk({nm, "_blank_and_sync"}, bad, 0);
  endtask

  // One pixel per cycle across every cell, compared two cycles later.
  task automatic scan(input string nm);
    int bad = 0;
    int first = -1;
    logic [3:0] got = 4'h0;
    for (int t = 0; t < 4802; t++) begin
      @(negedge clk);
      if (t >= 2 && sprite_code !== mdl[t-2]) begin
        if (bad == 0) begin first = t - 2; got = sprite_code; end
        bad++;
      end
      if (t < 4800) begin
        px = 10'((t % 80) * 8 + 3);
        py = 10'((t / 80) * 8 + 6);
        de_in = 1'b1;
      end else begin
        de_in = 1'b0;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cells wrong, first cell %0d got %h expected %h",
               nm, bad, first, got, mdl[first]);
    end
  endtask

  // Leaves wr_valid high so back-to-back calls issue one write per cycle.
  task automatic wr(input logic [6:0] c, input logic [5:0] r, input logic [3:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_col = c; wr_row = r; wr_code = d;
    chk("wr_ready_at_transfer", wr_ready, 1);
    if (c < 7'd80 && r < 6'd60) mdl[int'(r) * 80 + int'(c)] = d;
  endtask

  task automatic wr_idle();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; px = '0; py = '0; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_code = '0;

    vecs.push_back('{"tile_hit",    10'd29,  10'd21,  1, 0, 0, 1, 4'h9});
    vecs.push_back('{"neighbour",   10'd32,  10'd21,  1, 1, 0, 1, 4'hF});
    vecs.push_back('{"x_oob",       10'd700, 10'd21,  1, 0, 1, 0, 4'h0});
    vecs.push_back('{"de_low",      10'd100, 10'd21,  0, 1, 1, 0, 4'h0});
    vecs.push_back('{"tile_corner", 10'd24,  10'd16,  1, 0, 0, 1, 4'h9});
    vecs.push_back('{"y_edge",      10'd29,  10'd480, 1, 0, 0, 0, 4'h0});
    vecs.push_back('{"x_edge",      10'd640, 10'd21,  1, 0, 0, 0, 4'h0});
    vecs.push_back('{"last_cell",   10'd639, 10'd479, 1, 0, 0, 1, 4'h1});
    vecs.push_back('{"grid_x0",     10'd8,   10'd13,  1, 0, 0, 1, 4'h7});
    vecs.push_back('{"grid_off",    10'd9,   10'd13,  1, 0, 0, 1, 4'h7});
    vecs.push_back('{"grid_de0",    10'd8,   10'd13,  0, 0, 0, 0, 4'h0});
    vecs.push_back('{"burst_mid",   10'd50,  10'd45,  1, 1, 1, 1, 4'h4});

    repeat (3) @(negedge clk);
    chk("rst_sprite_code", sprite_code, 4'hF);
    chk("rst_sx_sy", {sx, sy}, 6'd0);
    chk("rst_timing", {de_out, hs_out, vs_out}, 3'd0);
    chk("rst_ready_done", {wr_ready, init_done}, 2'd0);
    hs_in = 1'b0; vs_in = 1'b0;

    rst_n = 1'b1;
    init_wait("init");
    fill_model();
    scan("init_scan");

    wr(7'd3, 6'd2, 4'h9);
    wr(7'd79, 6'd59, 4'h1);
    wr(7'd5, 6'd5, 4'h3);
    wr(7'd6, 6'd5, 4'h4);
    wr(7'd1, 6'd1, 4'h7);
    wr_idle();

    foreach (vecs[i]) begin
      @(negedge clk);
      px = vecs[i].px; py = vecs[i].py;
      de_in = vecs[i].de; hs_in = vecs[i].hs; vs_in = vecs[i].vs;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_code"}, sprite_code,
          exp_code(vecs[i].ram, vecs[i].ok, vecs[i].px[2:0], vecs[i].py[2:0]));
      chk({vecs[i].name, "_fields"}, {sx, sy, de_out, hs_out, vs_out},
          {vecs[i].px[2:0], vecs[i].py[2:0], vecs[i].de, vecs[i].hs, vecs[i].vs});
    end
    hs_in = 1'b0; vs_in = 1'b0;

    wr(7'd80, 6'd0, 4'h5);
    wr(7'd0, 6'd60, 4'h6);
    wr_idle();
    scan("oob_write_scan");

    // Write to cell 0 on the same edge the video path reads it.
    @(negedge clk); px = 10'd3; py = 10'd3; de_in = 1'b1;
    @(negedge clk); wr_valid = 1'b1; wr_col = 7'd0; wr_row = 6'd0; wr_code = 4'h2;
    @(negedge clk); wr_valid = 1'b0;
    chk("read_first_old", sprite_code, 4'hF);
    mdl[0] = 4'h2;
    @(negedge clk);
    chk("read_first_new", sprite_code, 4'h2);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("run_rst_ready_done", {wr_ready, init_done}, 2'd0);
    chk("run_rst_code", sprite_code, 4'hF);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("mid_sweep_ready", wr_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_sweep_rst_ready_done", {wr_ready, init_done}, 2'd0);
    rst_n = 1'b1;
    init_wait("restart");
    fill_model();
    scan("restart_scan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
